// File: rtl/ahb_slave_mem_if.sv
// AHB-Lite slave-side bus bundle: address/control, write data, bus ready in;
// slave ready, response and read data out.
interface ahb_slave_mem_if;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb_slave_mem.sv
// AHB-Lite slave memory: DEPTH x 32-bit byte-lane register file, programmable wait
// states, two-cycle ERROR on illegal access. Optional macro AHB_SLV_RO_REGION_EN.

module ahb_slave_mem_lane #(
  parameter int DEPTH = 16,
  parameter int IW    = 4,
  parameter int VEC_W = 8
) (
  input  logic             hclk,
  input  logic             hreset,
  input  logic             we,
  input  logic [IW-1:0]    idx,
  input  logic [VEC_W-1:0] wdata,
  output logic [VEC_W-1:0] rdata
);
  logic [VEC_W-1:0] mem [DEPTH];

  always_ff @(posedge hclk) begin
    if (hreset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[idx] <= wdata;
    end
  end

  assign rdata = mem[idx];
endmodule

module ahb_slave_mem #(
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 1,
  parameter int RO_WORDS    = 2
) (
  input  logic            hclk,
  input  logic            hreset,
  ahb_slave_mem_if.slave  bus
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;
  localparam int IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WS_LAST = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
`ifdef AHB_SLV_RO_REGION_EN
  localparam bit RO_EN = 1'b1;
`else
  localparam bit RO_EN = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DONE, S_ERR1, S_ERR2} state_t;

  typedef struct packed {
    logic [IW-1:0]        idx;
    logic                 wr;
    logic [NUM_LANES-1:0] be;
  } req_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  req_t req_q;
  logic take, accept, illegal, ro_err, rdy, resp;
  logic [9:0] widx;
  logic [NUM_LANES-1:0] be_n;
  logic [NUM_LANES-1:0][VEC_W-1:0] wdata_l, rdata_l;
  logic unused_bits;

  assign unused_bits = ^{bus.haddr[31:12], bus.htrans[0]};

  assign accept = bus.hsel & bus.hready & bus.htrans[1];
  assign widx   = bus.haddr[11:2];

  always_comb begin
    be_n = '0;
    case (bus.hsize)
      3'd0:    be_n = 4'b0001 << bus.haddr[1:0];
      3'd1:    be_n = bus.haddr[1] ? 4'b1100 : 4'b0011;
      default: be_n = 4'b1111;
    endcase
  end

  // Write-protect region only bites when the optional feature is compiled in.
  assign ro_err  = RO_EN & bus.hwrite & (32'(widx) < 32'(RO_WORDS));
  assign illegal = (bus.hsize > 3'd2)
                 | ((bus.hsize == 3'd1) & bus.haddr[0])
                 | ((bus.hsize == 3'd2) & (|bus.haddr[1:0]))
                 | (32'(widx) >= 32'(DEPTH))
                 | ro_err;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    take    = 1'b0;
    rdy     = 1'b1;
    resp    = 1'b0;
    case (state_q)
      S_WAIT: begin
        rdy = 1'b0;
        if (cnt_q == WS_LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_ERR1: begin
        rdy     = 1'b0;
        resp    = 1'b1;
        state_d = S_ERR2;
      end
      S_ERR2: begin
        resp    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Pipelined acceptance: a new address phase may overlap a completing data phase.
    if ((state_q inside {S_IDLE, S_DONE, S_ERR2}) && accept) begin
      take    = 1'b1;
      cnt_d   = '0;
      state_d = illegal ? S_ERR1 : ((WAIT_STATES > 0) ? S_WAIT : S_DONE);
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (take) req_q <= '{idx: widx[IW-1:0], wr: bus.hwrite, be: be_n};
    end
  end

  assign wdata_l = bus.hwdata;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    ahb_slave_mem_lane #(.DEPTH(DEPTH), .IW(IW), .VEC_W(VEC_W)) u_lane (
      .hclk   (hclk),
      .hreset (hreset),
      .we     ((state_q == S_DONE) & req_q.wr & req_q.be[l]),
      .idx    (req_q.idx),
      .wdata  (wdata_l[l]),
      .rdata  (rdata_l[l])
    );
  end

  assign bus.hreadyout = rdy;
  assign bus.hresp     = resp;
  assign bus.hrdata    = ((state_q == S_DONE) && !req_q.wr) ? rdata_l : '0;
endmodule

// File: tb/tb_ahb_slave_mem.sv
// Randomized self-checking bench for ahb_slave_mem: one DUT with one wait state,
// one zero-wait DUT for pipelined traffic, both against an array reference model.
module tb_ahb_slave_mem;
  logic hclk = 1'b0;
  logic hreset;
  int errs   = 0;
  int checks = 0;
  logic [31:0] mdl  [16];
  logic [31:0] mdl0 [16];
`ifdef AHB_SLV_RO_REGION_EN
  localparam bit RO_ON = 1'b1;
`else
  localparam bit RO_ON = 1'b0;
`endif
  localparam int RO_N = 1;

  always #5 hclk = ~hclk;

  ahb_slave_mem_if b1 ();
  ahb_slave_mem_if b0 ();
  assign b1.hready = b1.hreadyout;
  assign b0.hready = b0.hreadyout;

  ahb_slave_mem #(.DEPTH(16), .WAIT_STATES(1), .RO_WORDS(RO_N)) u_dut1 (
    .hclk(hclk), .hreset(hreset), .bus(b1));
  ahb_slave_mem #(.DEPTH(16), .WAIT_STATES(0), .RO_WORDS(RO_N)) u_dut0 (
    .hclk(hclk), .hreset(hreset), .bus(b0));

  function automatic bit mdl_legal(bit wr, logic [31:0] a, logic [2:0] sz);
    if (sz > 3'd2) return 1'b0;
    if (sz == 3'd1 && a[0]) return 1'b0;
    if (sz == 3'd2 && a[1:0] != 2'b00) return 1'b0;
    if (a[11:2] >= 10'd16) return 1'b0;
    if (RO_ON && wr && a[11:2] < 10'(RO_N)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] a,
                                        logic [2:0] sz, logic [31:0] wd);
    logic [31:0] m;
    if (sz == 3'd0)      m = 32'hFF << (8 * a[1:0]);
    else if (sz == 3'd1) m = 32'hFFFF << (16 * a[1]);
    else                 m = 32'hFFFF_FFFF;
    return (old & ~m) | (wd & m);
  endfunction

  task automatic go_idle();
    b1.hsel = 1'b0; b1.htrans = 2'b00; b1.hwrite = 1'b0; b1.hsize = 3'd2; b1.haddr = '0;
    b0.hsel = 1'b0; b0.htrans = 2'b00; b0.hwrite = 1'b0; b0.hsize = 3'd2; b0.haddr = '0;
  endtask

  // Single non-pipelined transfer on the one-wait-state DUT.
  task automatic xfer1(input bit wr, input logic [31:0] addr, input logic [2:0] sz,
                       input logic [31:0] wd, output logic [31:0] rd, output logic resp,
                       output bit err_wait, output int nwait);
    b1.hsel = 1'b1; b1.htrans = 2'b10; b1.haddr = addr; b1.hwrite = wr; b1.hsize = sz;
    @(posedge hclk); #1;
    b1.hsel = 1'b0; b1.htrans = 2'b00; b1.hwdata = wd;
    nwait = 0; err_wait = 1'b0; rd = '0; resp = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge hclk);
      if (b1.hreadyout === 1'b1) begin
        rd = b1.hrdata; resp = b1.hresp;
        break;
      end
      nwait++;
      if (b1.hresp === 1'b1) err_wait = 1'b1;
    end
    if (nwait >= 40) begin
      checks++; errs++;
      $display("FAIL timeout addr=%h: hreadyout never returned high", addr);
    end
    @(posedge hclk); #1;
  endtask

  task automatic test_reset();
    @(negedge hclk);
    checks++;
    if ({b1.hreadyout, b1.hresp, b1.hrdata} !== {1'b1, 1'b0, 32'h0}) begin
      errs++; $display("FAIL reset_ws1 got rdy=%b resp=%b rdata=%h want 1 0 0",
                       b1.hreadyout, b1.hresp, b1.hrdata);
    end
    checks++;
    if ({b0.hreadyout, b0.hresp, b0.hrdata} !== {1'b1, 1'b0, 32'h0}) begin
      errs++; $display("FAIL reset_ws0 got rdy=%b resp=%b rdata=%h want 1 0 0",
                       b0.hreadyout, b0.hresp, b0.hrdata);
    end
    @(posedge hclk); #1;
  endtask

  task automatic test_word_rw();
    logic [31:0] rd; logic resp; bit ew; int nw;
    xfer1(1'b1, 32'h04, 3'd2, 32'hDEAD_BEEF, rd, resp, ew, nw);
    mdl[1] = merge(mdl[1], 32'h04, 3'd2, 32'hDEAD_BEEF);
    checks++;
    if (nw !== 1 || resp !== 1'b0 || ew || rd !== 32'h0) begin
      errs++; $display("FAIL word_write waits=%0d resp=%b rdata=%h want 1 0 0", nw, resp, rd);
    end
    xfer1(1'b0, 32'h04, 3'd2, 32'h0, rd, resp, ew, nw);
    checks++;
    if (nw !== 1 || resp !== 1'b0 || ew || rd !== 32'hDEAD_BEEF) begin
      errs++; $display("FAIL word_read waits=%0d resp=%b rdata=%h want 1 0 deadbeef", nw, resp, rd);
    end
  endtask

  task automatic test_byte_half();
    logic [31:0] rd; logic resp; bit ew; int nw;
    xfer1(1'b1, 32'h05, 3'd0, 32'h0000_AA00, rd, resp, ew, nw);
    mdl[1] = merge(mdl[1], 32'h05, 3'd0, 32'h0000_AA00);
    xfer1(1'b0, 32'h04, 3'd2, 32'h0, rd, resp, ew, nw);
    checks++;
    if (rd !== 32'hDEAD_AAEF || resp !== 1'b0) begin
      errs++; $display("FAIL byte_write rdata=%h resp=%b want deadaaef 0", rd, resp);
    end
    xfer1(1'b1, 32'h06, 3'd1, 32'h1234_0000, rd, resp, ew, nw);
    mdl[1] = merge(mdl[1], 32'h06, 3'd1, 32'h1234_0000);
    xfer1(1'b0, 32'h04, 3'd2, 32'h0, rd, resp, ew, nw);
    checks++;
    if (rd !== 32'h1234_AAEF || resp !== 1'b0) begin
      errs++; $display("FAIL half_write rdata=%h resp=%b want 1234aaef 0", rd, resp);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic resp; bit ew; int nw;
    xfer1(1'b0, 32'h40, 3'd2, 32'h0, rd, resp, ew, nw);
    checks++;
    if (nw !== 1 || !ew || resp !== 1'b1 || rd !== 32'h0) begin
      errs++; $display("FAIL err_range waits=%0d err1=%b resp=%b rdata=%h want 1 1 1 0", nw, ew, resp, rd);
    end
    xfer1(1'b1, 32'h02, 3'd2, 32'hFFFF_FFFF, rd, resp, ew, nw);
    checks++;
    if (nw !== 1 || !ew || resp !== 1'b1) begin
      errs++; $display("FAIL err_align waits=%0d err1=%b resp=%b want 1 1 1", nw, ew, resp);
    end
    xfer1(1'b0, 32'h08, 3'd3, 32'h0, rd, resp, ew, nw);
    checks++;
    if (nw !== 1 || !ew || resp !== 1'b1 || rd !== 32'h0) begin
      errs++; $display("FAIL err_size waits=%0d err1=%b resp=%b rdata=%h want 1 1 1 0", nw, ew, resp, rd);
    end
    xfer1(1'b0, 32'h00, 3'd2, 32'h0, rd, resp, ew, nw);
    checks++;
    if (rd !== mdl[0] || resp !== 1'b0) begin
      errs++; $display("FAIL err_nowrite rdata=%h resp=%b want %h 0", rd, resp, mdl[0]);
    end
  endtask

  task automatic test_idle_busy();
    logic [31:0] rd; logic resp; bit ew; int nw;
    b1.hsel = 1'b1; b1.htrans = 2'b01; b1.hwrite = 1'b1; b1.haddr = 32'h04; b1.hsize = 3'd2;
    @(posedge hclk); #1;
    b1.hwdata = 32'hFFFF_FFFF;
    @(negedge hclk);
    checks++;
    if (b1.hreadyout !== 1'b1 || b1.hresp !== 1'b0) begin
      errs++; $display("FAIL busy rdy=%b resp=%b want 1 0", b1.hreadyout, b1.hresp);
    end
    @(posedge hclk); #1;
    b1.hsel = 1'b0; b1.htrans = 2'b10;
    @(posedge hclk); #1;
    @(negedge hclk);
    checks++;
    if (b1.hreadyout !== 1'b1 || b1.hresp !== 1'b0) begin
      errs++; $display("FAIL nosel rdy=%b resp=%b want 1 0", b1.hreadyout, b1.hresp);
    end
    @(posedge hclk); #1;
    go_idle();
    xfer1(1'b0, 32'h04, 3'd2, 32'h0, rd, resp, ew, nw);
    checks++;
    if (rd !== mdl[1]) begin
      errs++; $display("FAIL idle_nowrite rdata=%h want %h", rd, mdl[1]);
    end
  endtask

  task automatic test_ro();
    logic [31:0] rd; logic resp; bit ew; int nw; bit ok;
    ok = mdl_legal(1'b1, 32'h00, 3'd2);
    xfer1(1'b1, 32'h00, 3'd2, 32'h1122_3344, rd, resp, ew, nw);
    if (ok) mdl[0] = merge(mdl[0], 32'h00, 3'd2, 32'h1122_3344);
    checks++;
    if (resp !== RO_ON || ew !== RO_ON) begin
      errs++; $display("FAIL ro_write resp=%b err1=%b want %b", resp, ew, RO_ON);
    end
    xfer1(1'b0, 32'h00, 3'd2, 32'h0, rd, resp, ew, nw);
    checks++;
    if (rd !== mdl[0] || resp !== 1'b0) begin
      errs++; $display("FAIL ro_read rdata=%h resp=%b want %h 0", rd, resp, mdl[0]);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic resp; bit ew; int nw;
    b1.hsel = 1'b1; b1.htrans = 2'b10; b1.haddr = 32'h0C; b1.hwrite = 1'b1; b1.hsize = 3'd2;
    @(posedge hclk); #1;
    go_idle();
    b1.hwdata = 32'hCAFE_F00D;
    @(negedge hclk);
    checks++;
    if (b1.hreadyout !== 1'b0) begin
      errs++; $display("FAIL mid_wait rdy=%b want 0", b1.hreadyout);
    end
    hreset = 1'b1;
    @(posedge hclk); #1;
    hreset = 1'b0;
    for (int i = 0; i < 16; i++) begin mdl[i] = '0; mdl0[i] = '0; end
    @(negedge hclk);
    checks++;
    if (b1.hreadyout !== 1'b1 || b1.hresp !== 1'b0) begin
      errs++; $display("FAIL mid_reset rdy=%b resp=%b want 1 0", b1.hreadyout, b1.hresp);
    end
    @(posedge hclk); #1;
    xfer1(1'b0, 32'h0C, 3'd2, 32'h0, rd, resp, ew, nw);
    checks++;
    if (rd !== 32'h0) begin
      errs++; $display("FAIL mid_nowrite rdata=%h want 0", rd);
    end
    xfer1(1'b0, 32'h04, 3'd2, 32'h0, rd, resp, ew, nw);
    checks++;
    if (rd !== 32'h0) begin
      errs++; $display("FAIL mid_clear rdata=%h want 0", rd);
    end
  endtask

  // Zero-wait DUT: address phase of op c overlaps data phase of op c-1.
  task automatic test_back_to_back();
    logic [31:0] ad [8];
    logic [31:0] dt [8];
    bit w [8];
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) ad[i] = 32'($urandom_range(RO_N, 15)) << 2;
      else            ad[i] = ad[i-1];
      w[i]  = (i % 2 == 0);
      dt[i] = $urandom;
    end
    for (int c = 0; c <= 8; c++) begin
      if (c < 8) begin
        b0.hsel = 1'b1; b0.htrans = 2'b10; b0.haddr = ad[c]; b0.hwrite = w[c]; b0.hsize = 3'd2;
      end else begin
        b0.hsel = 1'b0; b0.htrans = 2'b00;
      end
      if (c > 0) b0.hwdata = dt[c-1];
      @(negedge hclk);
      if (c > 0) begin
        checks++;
        if (b0.hreadyout !== 1'b1 || b0.hresp !== 1'b0) begin
          errs++; $display("FAIL b2b_rdy op=%0d rdy=%b resp=%b want 1 0", c-1, b0.hreadyout, b0.hresp);
        end
        if (!w[c-1]) begin
          checks++;
          if (b0.hrdata !== mdl0[ad[c-1][5:2]]) begin
            errs++; $display("FAIL b2b_read op=%0d rdata=%h want %h", c-1, b0.hrdata, mdl0[ad[c-1][5:2]]);
          end
        end else begin
          mdl0[ad[c-1][5:2]] = dt[c-1];
        end
      end
      @(posedge hclk); #1;
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, a, wd, exp_rd; logic resp; bit ew, wr, ok; int nw; logic [2:0] sz;
    for (int n = 0; n < 60; n++) begin
      wr = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, 71));
      wd = $urandom;
      ok = mdl_legal(wr, a, sz);
      exp_rd = (ok && !wr) ? mdl[a[5:2]] : 32'h0;
      xfer1(wr, a, sz, wd, rd, resp, ew, nw);
      checks++;
      if (resp !== !ok || ew !== !ok || nw !== 1) begin
        errs++; $display("FAIL rand_resp n=%0d a=%h sz=%0d wr=%b resp=%b err1=%b waits=%0d want resp=%b waits=1",
                         n, a, sz, wr, resp, ew, nw, !ok);
      end
      checks++;
      if (rd !== exp_rd) begin
        errs++; $display("FAIL rand_rdata n=%0d a=%h sz=%0d wr=%b rdata=%h want %h", n, a, sz, wr, rd, exp_rd);
      end
      if (ok && wr) mdl[a[5:2]] = merge(mdl[a[5:2]], a, sz, wd);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    hreset = 1'b1;
    go_idle();
    b1.hwdata = '0; b0.hwdata = '0;
    for (int i = 0; i < 16; i++) begin mdl[i] = '0; mdl0[i] = '0; end
    repeat (3) @(posedge hclk);
    #1 hreset = 1'b0;
    test_reset();
    test_word_rw();
    test_byte_half();
    test_errors();
    test_idle_busy();
    test_ro();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
